// File: rtl/instr_encoder.sv
// rtl/instr_encoder.sv - field-tuple to 32-bit instruction encoder with 2-entry output FIFO and address counter
// Optional macro ENC_IMM_CHECK_EN: drop out-of-range I-format immediates and pulse err.
module instr_encoder #(
  parameter int ADDR_W = 12
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_fmt,
  input  logic [4:0]        in_opcode,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_shamt,
  input  logic [4:0]        in_aluop,
  input  logic [31:0]       in_imm,
  input  logic [26:0]       in_target,
  input  logic              addr_load,
  input  logic [ADDR_W-1:0] addr_val,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_word,
  output logic [ADDR_W-1:0] out_addr,
  output logic              err
);

  localparam logic [1:0] FMT_R   = 2'd0;
  localparam logic [1:0] FMT_I   = 2'd1;
  localparam logic [1:0] FMT_JI  = 2'd2;
  localparam logic [1:0] FMT_JII = 2'd3;

  logic [31:0]       r_word [2];
  logic [ADDR_W-1:0] r_addr [2];
  logic              r_wr_ptr;
  logic              r_rd_ptr;
  logic [1:0]        r_count;
  logic [ADDR_W-1:0] r_cnt;
  logic              r_rdy_en;

  logic [31:0]       w_word;
  logic [ADDR_W-1:0] w_wr_addr;
  logic              w_accept;
  logic              w_imm_bad;
  logic              w_push;
  logic              w_pop;

  always_comb begin
    w_word = {in_opcode, 27'd0};
    case (in_fmt)
      FMT_R:   w_word = {in_opcode, in_rd, in_rs, in_rt, in_shamt, in_aluop, 2'b00};
      FMT_I:   w_word = {in_opcode, in_rd, in_rs, in_imm[16:0]};
      FMT_JI:  w_word = {in_opcode, in_target};
      FMT_JII: w_word = {in_opcode, in_rd, 22'd0};
      default: w_word = {in_opcode, 27'd0};
    endcase
  end

`ifdef ENC_IMM_CHECK_EN
  logic r_err;

  assign w_imm_bad = (in_fmt == FMT_I) &&
                     (($signed(in_imm) < -32'sd65536) || ($signed(in_imm) > 32'sd65535));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_err <= 1'b0;
    else        r_err <= w_accept & w_imm_bad;
  end

  assign err = r_err;
`else
  logic w_unused_imm;

  assign w_unused_imm = ^in_imm[31:17];
  assign w_imm_bad    = 1'b0;
  assign err          = 1'b0;
`endif

  assign in_ready  = r_rdy_en & (r_count != 2'd2);
  assign out_valid = (r_count != 2'd0);
  assign out_word  = r_word[r_rd_ptr];
  assign out_addr  = r_addr[r_rd_ptr];

  assign w_accept  = in_valid & in_ready;
  assign w_push    = w_accept & ~w_imm_bad;
  assign w_pop     = out_valid & out_ready;
  // A same-cycle load overrides the counter for the word being pushed.
  assign w_wr_addr = addr_load ? addr_val : r_cnt;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_rdy_en <= 1'b0;
    else        r_rdy_en <= 1'b1;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (w_push) begin
      r_cnt <= w_wr_addr + ADDR_W'(1);
    end else if (addr_load) begin
      r_cnt <= addr_val;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_word[0] <= '0;
      r_word[1] <= '0;
      r_addr[0] <= '0;
      r_addr[1] <= '0;
      r_wr_ptr  <= 1'b0;
      r_rd_ptr  <= 1'b0;
      r_count   <= 2'd0;
    end else begin
      if (w_push) begin
        r_word[r_wr_ptr] <= w_word;
        r_addr[r_wr_ptr] <= w_wr_addr;
        r_wr_ptr         <= ~r_wr_ptr;
      end
      if (w_pop) r_rd_ptr <= ~r_rd_ptr;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// tb/tb_instr_encoder.sv - scoreboard bench for instr_encoder
module tb_instr_encoder;

  localparam int ADDR_W = 12;

  typedef struct {
    logic [31:0]       word;
    logic [ADDR_W-1:0] addr;
  } exp_t;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [1:0]        in_fmt = '0;
  logic [4:0]        in_opcode = '0, in_rd = '0, in_rs = '0, in_rt = '0, in_shamt = '0, in_aluop = '0;
  logic [31:0]       in_imm = '0;
  logic [26:0]       in_target = '0;
  logic              addr_load = 1'b0;
  logic [ADDR_W-1:0] addr_val = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [31:0]       out_word;
  logic [ADDR_W-1:0] out_addr;
  logic              err;

  exp_t              q[$];
  logic [ADDR_W-1:0] m_addr = '0;
  logic              m_rdy_en = 1'b0;
  logic              m_err_exp = 1'b0;
  logic              accepted = 1'b0;
  int                n_checks = 0;
  int                n_pass = 0;

  instr_encoder #(.ADDR_W(ADDR_W)) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_fmt(in_fmt),
    .in_opcode(in_opcode), .in_rd(in_rd), .in_rs(in_rs), .in_rt(in_rt),
    .in_shamt(in_shamt), .in_aluop(in_aluop), .in_imm(in_imm), .in_target(in_target),
    .addr_load(addr_load), .addr_val(addr_val),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_word(out_word), .out_addr(out_addr), .err(err)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  function automatic logic [31:0] enc(input logic [1:0] fmt, input logic [4:0] op, rd, rs, rt, sh, alu,
                                      input logic [31:0] imm, input logic [26:0] tgt);
    logic [31:0] w;
    w = 32'(op) << 27;
    if (fmt == 2'd0) w = w | (32'(rd) << 22) | (32'(rs) << 17) | (32'(rt) << 12) | (32'(sh) << 7) | (32'(alu) << 2);
    else if (fmt == 2'd1) w = w | (32'(rd) << 22) | (32'(rs) << 17) | (imm & 32'h0001_FFFF);
    else if (fmt == 2'd2) w = w | 32'(tgt);
    else w = w | (32'(rd) << 22);
    return w;
  endfunction

  function automatic logic imm_bad();
`ifdef ENC_IMM_CHECK_EN
    return (in_fmt == 2'd1) && (($signed(in_imm) < -65536) || ($signed(in_imm) > 65535));
`else
    return 1'b0;
`endif
  endfunction

  // One clock: compare at the falling edge, advance the model, return 1 time unit after the rising edge.
  task automatic step();
    exp_t e;
    logic [ADDR_W-1:0] a;
    logic rdy, pop;
    @(negedge clock);
    rdy = m_rdy_en && (q.size() < 2);
    pop = (q.size() != 0) && out_ready;
    check("in_ready", 32'(in_ready), 32'(rdy));
    check("out_valid", 32'(out_valid), 32'(q.size() != 0));
    check("err", 32'(err), 32'(m_err_exp));
    if (q.size() != 0) begin
      check("head_word", out_word, q[0].word);
      check("head_addr", 32'(out_addr), 32'(q[0].addr));
    end
    if (pop) e = q.pop_front();
    accepted = in_valid && rdy;
    m_err_exp = 1'b0;
    if (accepted && imm_bad()) begin
      m_err_exp = 1'b1;
      if (addr_load) m_addr = addr_val;
    end else if (accepted) begin
      a = addr_load ? addr_val : m_addr;
      e.word = enc(in_fmt, in_opcode, in_rd, in_rs, in_rt, in_shamt, in_aluop, in_imm, in_target);
      e.addr = a;
      q.push_back(e);
      m_addr = a + 1'b1;
    end else if (addr_load) begin
      m_addr = addr_val;
    end
    @(posedge clock);
    m_rdy_en = reset;
    #1;
  endtask

  task automatic set_tuple(input logic [1:0] fmt, input logic [4:0] op, rd, rs, rt, sh, alu,
                           input logic [31:0] imm, input logic [26:0] tgt);
    in_fmt = fmt; in_opcode = op; in_rd = rd; in_rs = rs; in_rt = rt;
    in_shamt = sh; in_aluop = alu; in_imm = imm; in_target = tgt;
  endtask

  task automatic offer(input logic load, input logic [ADDR_W-1:0] lval);
    int n;
    in_valid = 1'b1; addr_load = load; addr_val = lval;
    n = 0;
    do begin
      step();
      n++;
    end while (!accepted && n < 50);
    if (!accepted) check("accept_timeout", 32'd0, 32'd1);
    in_valid = 1'b0; addr_load = 1'b0;
  endtask

  task automatic drain();
    int n;
    out_ready = 1'b1;
    n = 0;
    while (q.size() != 0 && n < 20) begin
      step();
      n++;
    end
    check("drain_empty", 32'(q.size()), 32'd0);
  endtask

  initial begin
    #1 reset = 1'b0;
    #20;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_word", out_word, 32'd0);
    check("rst_out_addr", 32'(out_addr), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    @(posedge clock); #1 reset = 1'b1;
    step();
    check("ready_after_rst", 32'(in_ready), 32'd1);

    // R-format at address 0, visible one cycle after acceptance
    set_tuple(2'd0, 5'd0, 5'd3, 5'd1, 5'd2, 5'd0, 5'd0, 32'd0, 27'd0);
    offer(1'b0, '0);
    check("r_valid", 32'(out_valid), 32'd1);
    check("r_word", out_word, 32'h00C2_2000);
    check("r_addr", 32'(out_addr), 32'h000);
    drain();

    // I-format, positive then negative immediate at consecutive addresses
    out_ready = 1'b0;
    set_tuple(2'd1, 5'd5, 5'd1, 5'd0, 5'd0, 5'd0, 5'd0, 32'd5, 27'd0);
    offer(1'b0, '0);
    check("i_word0", out_word, 32'h2840_0005);
    check("i_addr0", 32'(out_addr), 32'h001);
    set_tuple(2'd1, 5'd5, 5'd1, 5'd0, 5'd0, 5'd0, 5'd0, 32'hFFFF_FFFF, 27'd0);
    offer(1'b0, '0);
    out_ready = 1'b1;
    step();
    check("i_word1", out_word, 32'h2841_FFFF);
    check("i_addr1", 32'(out_addr), 32'h002);
    drain();

    // JI with same-cycle counter load at the top address, then wrap
    out_ready = 1'b0;
    set_tuple(2'd2, 5'd1, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 32'd0, 27'h100);
    offer(1'b1, 12'hFFF);
    check("ji_word", out_word, 32'h0800_0100);
    check("ji_addr", 32'(out_addr), 32'hFFF);
    set_tuple(2'd3, 5'd2, 5'd7, 5'd0, 5'd0, 5'd0, 5'd0, 32'd0, 27'd0);
    offer(1'b0, '0);
    // Loading while entries are held must not disturb them
    addr_load = 1'b1; addr_val = 12'h001;
    step();
    addr_load = 1'b0;
    out_ready = 1'b1;
    step();
    check("wrap_addr", 32'(out_addr), 32'h000);
    drain();

    // Backpressure: third tuple waits until the consumer drains
    out_ready = 1'b0;
    set_tuple(2'd0, 5'd3, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 32'd0, 27'd0);
    offer(1'b0, '0);
    set_tuple(2'd1, 5'd4, 5'd6, 5'd7, 5'd0, 5'd0, 5'd0, 32'd1234, 27'd0);
    offer(1'b0, '0);
    set_tuple(2'd3, 5'd9, 5'd10, 5'd0, 5'd0, 5'd0, 5'd0, 32'd0, 27'd0);
    in_valid = 1'b1;
    repeat (3) step();
    check("bp_in_ready", 32'(in_ready), 32'd0);
    check("bp_held_addr", 32'(out_addr), 32'h001);
    out_ready = 1'b1;
    offer(1'b0, '0);
    drain();

    // Out-of-range immediate
    out_ready = 1'b0;
    set_tuple(2'd1, 5'd5, 5'd1, 5'd0, 5'd0, 5'd0, 5'd0, 32'd70000, 27'd0);
    offer(1'b0, '0);
`ifdef ENC_IMM_CHECK_EN
    check("imm_err", 32'(err), 32'd1);
    check("imm_no_valid", 32'(out_valid), 32'd0);
    step();
    check("imm_err_1cyc", 32'(err), 32'd0);
`else
    check("imm_trunc_word", out_word, 32'h2841_1170);
    check("imm_trunc_addr", 32'(out_addr), 32'h004);
    check("imm_err_tied", 32'(err), 32'd0);
`endif
    drain();
    out_ready = 1'b0;
    set_tuple(2'd2, 5'd6, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 32'd0, 27'h7ABCDE);
    offer(1'b0, '0);
`ifdef ENC_IMM_CHECK_EN
    check("imm_cnt_kept", 32'(out_addr), 32'h004);
`else
    check("imm_cnt_kept", 32'(out_addr), 32'h005);
`endif
    drain();

    // Reset with two entries held
    out_ready = 1'b0;
    set_tuple(2'd0, 5'd1, 5'd1, 5'd1, 5'd1, 5'd1, 5'd1, 32'd0, 27'd0);
    offer(1'b0, '0);
    offer(1'b0, '0);
    #2 reset = 1'b0;
    #1;
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_ready", 32'(in_ready), 32'd0);
    check("mid_rst_word", out_word, 32'd0);
    q.delete();
    m_addr = '0; m_rdy_en = 1'b0; m_err_exp = 1'b0;
    @(posedge clock); #1 reset = 1'b1;
    set_tuple(2'd0, 5'd0, 5'd3, 5'd1, 5'd2, 5'd0, 5'd0, 32'd0, 27'd0);
    offer(1'b0, '0);
    check("post_rst_addr", 32'(out_addr), 32'h000);
    check("post_rst_word", out_word, 32'h00C2_2000);
    drain();

    // Random traffic with simultaneous push/pop and occasional loads
    for (int i = 0; i < 300; i++) begin
      set_tuple(2'($urandom_range(0, 3)), 5'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
                5'($urandom), 5'($urandom),
                ($urandom_range(0, 7) == 0) ? 32'($urandom) : 32'($urandom_range(0, 131071)) - 32'd65536,
                27'($urandom));
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      addr_load = ($urandom_range(0, 15) == 0);
      addr_val  = 12'($urandom);
      step();
    end
    in_valid = 1'b0; addr_load = 1'b0;
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 SHALL have parameter ADDR_W, default 12, meaning width of the instruction-memory write address counter.
REQ-002 SHALL have port clock, input, 1, meaning the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1, meaning asynchronous, active-low reset.
REQ-004 SHALL have port in_valid, input, 1, meaning the field tuple on in_* is offered.
REQ-005 SHALL have port in_ready, output, 1, meaning the encoder accepts the tuple this cycle.
REQ-006 SHALL have port in_fmt, input, 2, meaning the format: 0=R, 1=I, 2=JI, 3=JII.
REQ-007 SHALL have ports in_opcode, in_rd, in_rs, in_rt, in_shamt, in_aluop, each input, 5, meaning the instruction fields.
REQ-008 SHALL have port in_imm, input, 32, meaning a signed immediate.
REQ-009 SHALL have port in_target, input, 27, meaning the jump target.
REQ-010 SHALL have port addr_load, input, 1, and port addr_val, input, ADDR_W, meaning preset the address counter.
REQ-011 SHALL have port out_valid, output, 1, meaning out_word/out_addr hold an encoded instruction.
REQ-012 SHALL have port out_ready, input, 1, meaning the consumer (imem writer) takes the word.
REQ-013 SHALL have port out_word, output, 32, and port out_addr, output, ADDR_W, meaning the encoded word and its address.
REQ-014 SHALL have port err, output, 1, meaning a one-cycle immediate-range error pulse.

Function
REQ-015 SHALL pack opcode to [31:27] for all formats.
REQ-016 SHALL pack R: rd[26:22], rs[21:17], rt[16:12], shamt[11:7], aluop[6:2], [1:0]=0.
REQ-017 SHALL pack I: rd[26:22], rs[21:17], in_imm[16:0] to [16:0].
REQ-018 SHALL pack JI: in_target to [26:0]; JII: rd[26:22], [21:0]=0.
REQ-019 SHALL accept a tuple when in_valid and in_ready are both high, and push {word, address} into a 2-entry FIFO.
REQ-020 SHALL drive in_ready = FIFO not full, so no tuple is accepted while 2 entries are held.
REQ-021 SHALL present the head entry on out_* one cycle after acceptance into an empty FIFO; out_valid = FIFO not empty.
REQ-022 SHALL pop on out_valid and out_ready; simultaneous push and pop with 1 entry keeps the count at 1 and preserves order.
REQ-023 SHALL hold out_word and out_addr stable while out_valid is high and out_ready is low.
REQ-024 SHALL assign each pushed word the current counter value, then increment the counter, wrapping from 2^ADDR_W-1 to 0.
REQ-025 SHALL, on addr_load, set the counter to addr_val; if a push happens the same cycle, the pushed word takes addr_val and the counter becomes addr_val+1.
REQ-026 SHALL leave entries already in the FIFO unchanged by addr_load.

Reset
REQ-027 SHALL, on reset low, immediately clear the FIFO, counter and err, and drive out_valid=0, out_word=0, out_addr=0 and in_ready=0.
REQ-028 SHALL drive in_ready=1 from the first clock edge after reset deasserts.
REQ-029 SHALL discard in-flight entries when reset is asserted mid-operation.

Configuration
REQ-030 SHALL, with ENC_IMM_CHECK_EN defined, accept an I-format tuple with in_imm outside [-65536, 65535] without pushing it or advancing the counter, and pulse err high for exactly one cycle.
REQ-031 SHALL, without ENC_IMM_CHECK_EN, truncate in_imm to [16:0], push every tuple, and tie err to 0.

Verification
REQ-032 SHALL cover: R, opcode 0, rd 3, rs 1, rt 2, shamt 0, aluop 0, counter 0 -> out_word 0x00C22000, out_addr 0x000 one cycle later.
REQ-033 SHALL cover: I, opcode 5, rd 1, rs 0, imm 5, then imm -1 -> 0x28400005, then 0x2841FFFF at consecutive addresses.
REQ-034 SHALL cover: JI, opcode 1, target 0x100, with addr_load and addr_val 0xFFF the same cycle -> 0x08000100 at 0xFFF; the next word is at 0x000.
REQ-035 SHALL cover: out_ready held low and 3 tuples offered -> in_ready low after 2 accepts; outputs stable; order kept once out_ready rises.
REQ-036 SHALL cover: with ENC_IMM_CHECK_EN, I imm 70000 -> no out_valid, err high 1 cycle, counter unchanged; without the macro -> word 0x284(0x11170 masked) = 0x28411170.
REQ-037 SHALL cover: reset asserted with 2 entries held -> out_valid 0 immediately; after release the first word is at addr 0.
